// File: rtl/grayscale_frame_reader.sv
// Streams one grayscale byte per pixel out of a byte-replicated (3 bytes per pixel) buffer
// and flags any triplet whose bytes disagree.
module grayscale_frame_reader #(
    parameter int unsigned RESULT_ARRAY_LEN = 51200,
    parameter int unsigned ADDR_W           = 16,
    parameter int unsigned PIXEL_COUNT      = 17066
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        pix_data,
    output logic              mismatch,
    output logic              done
);

    localparam int unsigned CNT_W = (PIXEL_COUNT > 1) ? $clog2(PIXEL_COUNT) : 1;
    localparam logic [CNT_W-1:0] LastPix = CNT_W'(PIXEL_COUNT - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StDrain   = 3'd2;
    localparam logic [2:0] StPresent = 3'd3;
    localparam logic [2:0] StFinish  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        k_q, k_d;
    logic [7:0]        b0_q, b0_d;
    logic [7:0]        b1_q, b1_d;
    logic [7:0]        pix_q, pix_d;
    logic              mism_q, mism_d;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        pix_d   = pix_q;
        mism_d  = mism_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    base_d  = '0;
                    cnt_d   = '0;
                    k_d     = 2'd0;
                    mism_d  = 1'b0;
                    state_d = StFetch;
                end
            end
            StFetch: begin
                // Read data lags the strobe by one cycle, so byte k-1 arrives while k is issued.
                k_d = k_q + 2'd1;
                if (k_q == 2'd1) begin
                    b0_d = mem_rd_data;
                end
                if (k_q == 2'd2) begin
                    b1_d    = mem_rd_data;
                    k_d     = 2'd0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                pix_d   = b0_q;
                mism_d  = mism_q | (b1_q != b0_q) | (mem_rd_data != b0_q);
                state_d = StPresent;
            end
            StPresent: begin
                if (pix_ready) begin
                    if (cnt_q == LastPix) begin
                        state_d = StFinish;
                    end else begin
                        base_d  = base_q + ADDR_W'(3);
                        cnt_d   = cnt_q + CNT_W'(1);
                        k_d     = 2'd0;
                        state_d = StFetch;
                    end
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            base_q  <= '0;
            cnt_q   <= '0;
            k_q     <= 2'd0;
            b0_q    <= 8'd0;
            b1_q    <= 8'd0;
            pix_q   <= 8'd0;
            mism_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            pix_q   <= pix_d;
            mism_q  <= mism_d;
        end
    end

    always_comb begin
        busy      = (state_q != StIdle);
        mem_rd_en = (state_q == StFetch);
        mem_addr  = mem_rd_en ? (base_q + ADDR_W'(k_q)) : '0;
        pix_valid = (state_q == StPresent);
        pix_data  = pix_q;
        mismatch  = mism_q;
        done      = (state_q == StFinish);
    end

endmodule

// File: tb/tb_grayscale_frame_reader.sv
// Directed bench for grayscale_frame_reader with a 4-pixel frame and a 1-cycle-latency memory.
module tb_grayscale_frame_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data = 8'd0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [7:0]  pix_data;
    logic        mismatch;
    logic        done;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] mem [0:15];
    bit         v_log [64];
    bit         b_log [64];
    bit         m_log [64];
    bit         r_log [64];
    logic [7:0] d_log [64];
    int         addr_q [$];
    int         hs_val [$];
    int         hs_cyc [$];
    int         done_q [$];

    grayscale_frame_reader #(
        .RESULT_ARRAY_LEN(51200),
        .ADDR_W(16),
        .PIXEL_COUNT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .pix_data(pix_data),
        .mismatch(mismatch),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr[3:0]];
    end

    task automatic load_mem();
        for (int i = 0; i < 16; i++) mem[i] = 8'(10 * (i / 3 + 1));
    endtask

    // Entered just after a rising edge; cycle c is the period following that edge.
    task automatic run_cycles(input int n, input int s0, input int s1, input int s2,
                              input int st_lo, input int st_hi);
        addr_q.delete();
        hs_val.delete();
        hs_cyc.delete();
        done_q.delete();
        for (int c = 0; c < n; c++) begin
            start = (c == s0) || (c == s1) || (c == s2);
            pix_ready = !(c >= st_lo && c < st_hi);
            @(negedge clk);
            v_log[c] = pix_valid;
            b_log[c] = busy;
            m_log[c] = mismatch;
            r_log[c] = mem_rd_en;
            d_log[c] = pix_data;
            if (mem_rd_en) addr_q.push_back(int'(mem_addr));
            if (pix_valid && pix_ready) begin
                hs_val.push_back(int'(pix_data));
                hs_cyc.push_back(c);
            end
            if (done) done_q.push_back(c);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        pix_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, mem_rd_en, mem_addr, pix_valid, pix_data, mismatch, done} !== 29'd0)
            $display("FAIL reset_initial: outputs=%h want 0",
                     {busy, mem_rd_en, mem_addr, pix_valid, pix_data, mismatch, done});
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        // Stall the first pixel so it is held on the stream, then reset between edges.
        run_cycles(6, 0, -1, -1, 5, 100);
        n_total++;
        if ({pix_valid, pix_data} !== {1'b1, 8'd10})
            $display("FAIL reset_prestate: valid/data=%h want 10a", {pix_valid, pix_data});
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, mem_rd_en, mem_addr, pix_valid, pix_data, mismatch, done} !== 29'd0)
            $display("FAIL reset_async: outputs=%h want 0",
                     {busy, mem_rd_en, mem_addr, pix_valid, pix_data, mismatch, done});
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_nominal();
        int bad;
        run_cycles(24, 0, -1, -1, 0, 0);
        n_total++;
        if (b_log[0] !== 1'b0 || b_log[1] !== 1'b1)
            $display("FAIL nom_busy_rise: c0=%0d c1=%0d want 0 1", b_log[0], b_log[1]);
        else n_pass++;
        n_total++;
        if (v_log[4] !== 1'b0 || v_log[5] !== 1'b1)
            $display("FAIL nom_first_valid: c4=%0d c5=%0d want 0 1", v_log[4], v_log[5]);
        else n_pass++;
        n_total++;
        if (hs_val.size() !== 4) $display("FAIL nom_pix_count: got %0d want 4", hs_val.size());
        else n_pass++;
        for (int i = 0; i < hs_val.size() && i < 4; i++) begin
            n_total++;
            if (hs_val[i] !== 10 * (i + 1) || hs_cyc[i] !== 5 + 5 * i)
                $display("FAIL nom_pix%0d: data=%0d cyc=%0d want %0d at %0d",
                         i, hs_val[i], hs_cyc[i], 10 * (i + 1), 5 + 5 * i);
            else n_pass++;
        end
        n_total++;
        if (done_q.size() !== 1 || (done_q.size() > 0 && done_q[0] !== 21))
            $display("FAIL nom_done: count=%0d first=%0d want 1 at 21", done_q.size(),
                     done_q.size() > 0 ? done_q[0] : -1);
        else n_pass++;
        n_total++;
        if (b_log[21] !== 1'b1 || b_log[22] !== 1'b0)
            $display("FAIL nom_busy_fall: c21=%0d c22=%0d want 1 0", b_log[21], b_log[22]);
        else n_pass++;
        n_total++;
        if (m_log[21] !== 1'b0) $display("FAIL nom_mismatch: got %0d want 0", m_log[21]);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== i) bad++;
        n_total++;
        if (addr_q.size() !== 12 || bad !== 0)
            $display("FAIL nom_addr_seq: reads=%0d wrong=%0d want 12 0", addr_q.size(), bad);
        else n_pass++;
        bad = 0;
        for (int c = 0; c < 24; c++) if (v_log[c] && r_log[c]) bad++;
        n_total++;
        if (bad !== 0) $display("FAIL nom_no_prefetch: overlap=%0d want 0", bad);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int held;
        int reads;
        int bad;
        run_cycles(32, 0, -1, -1, 5, 12);
        held = 0;
        reads = 0;
        for (int c = 5; c < 12; c++) begin
            if (v_log[c] && d_log[c] === 8'd10) held++;
            if (r_log[c]) reads++;
        end
        n_total++;
        if (held !== 7) $display("FAIL bp_held: got %0d cycles want 7", held);
        else n_pass++;
        n_total++;
        if (reads !== 0) $display("FAIL bp_no_reads: got %0d want 0", reads);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < hs_val.size(); i++)
            if (hs_val[i] !== 10 * (i + 1) || hs_cyc[i] !== 12 + 5 * i) bad++;
        n_total++;
        if (hs_val.size() !== 4 || bad !== 0)
            $display("FAIL bp_pixels: count=%0d wrong=%0d want 4 0", hs_val.size(), bad);
        else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || (done_q.size() > 0 && done_q[0] !== 28))
            $display("FAIL bp_done: count=%0d want 1 at 28", done_q.size());
        else n_pass++;
    endtask

    task automatic test_mismatch();
        mem[4] = 8'd21;
        run_cycles(24, 0, -1, -1, 0, 0);
        n_total++;
        if (m_log[9] !== 1'b0 || m_log[10] !== 1'b1 || d_log[10] !== 8'd20)
            $display("FAIL mm_rise: c9=%0d c10=%0d data=%0d want 0 1 20",
                     m_log[9], m_log[10], d_log[10]);
        else n_pass++;
        n_total++;
        if (m_log[21] !== 1'b1 || m_log[22] !== 1'b1)
            $display("FAIL mm_sticky: c21=%0d c22=%0d want 1 1", m_log[21], m_log[22]);
        else n_pass++;
        n_total++;
        if (hs_val.size() < 2 || hs_val[1] !== 20)
            $display("FAIL mm_pix1: got %0d want 20", hs_val.size() < 2 ? -1 : hs_val[1]);
        else n_pass++;
        run_cycles(3, 0, -1, -1, 0, 0);
        n_total++;
        if (m_log[0] !== 1'b1 || m_log[1] !== 1'b0)
            $display("FAIL mm_clear: c0=%0d c1=%0d want 1 0", m_log[0], m_log[1]);
        else n_pass++;
        mem[4] = 8'd20;
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        int busy_cnt;
        run_cycles(12, 0, -1, -1, 0, 0);
        n_total++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 16'd7)
            $display("FAIL rmf_prestate: rd_en=%0d addr=%0d want 1 7", mem_rd_en, mem_addr);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, mem_rd_en, mem_addr, pix_valid, pix_data, mismatch, done} !== 29'd0)
            $display("FAIL rmf_outputs: outputs=%h want 0",
                     {busy, mem_rd_en, mem_addr, pix_valid, pix_data, mismatch, done});
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b0;
        run_cycles(8, -1, -1, -1, 0, 0);
        busy_cnt = 0;
        for (int c = 0; c < 8; c++) if (b_log[c]) busy_cnt++;
        n_total++;
        if (done_q.size() !== 0 || busy_cnt !== 0)
            $display("FAIL rmf_no_done: dones=%0d busy=%0d want 0 0", done_q.size(), busy_cnt);
        else n_pass++;
        run_cycles(24, 0, -1, -1, 0, 0);
        bad = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== i) bad++;
        for (int i = 0; i < hs_val.size(); i++) if (hs_val[i] !== 10 * (i + 1)) bad++;
        n_total++;
        if (addr_q.size() !== 12 || hs_val.size() !== 4 || bad !== 0)
            $display("FAIL rmf_restart: reads=%0d pixels=%0d wrong=%0d want 12 4 0",
                     addr_q.size(), hs_val.size(), bad);
        else n_pass++;
        n_total++;
        if (done_q.size() !== 1 || (done_q.size() > 0 && done_q[0] !== 21))
            $display("FAIL rmf_done: count=%0d want 1 at 21", done_q.size());
        else n_pass++;
    endtask

    task automatic test_illegal_start();
        int bad;
        int busy_cnt;
        run_cycles(28, 0, 7, 21, 0, 0);
        n_total++;
        if (done_q.size() !== 1 || (done_q.size() > 0 && done_q[0] !== 21))
            $display("FAIL ill_done: count=%0d want 1 at 21", done_q.size());
        else n_pass++;
        bad = 0;
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== i) bad++;
        n_total++;
        if (addr_q.size() !== 12 || bad !== 0)
            $display("FAIL ill_addr_seq: reads=%0d wrong=%0d want 12 0", addr_q.size(), bad);
        else n_pass++;
        busy_cnt = 0;
        for (int c = 22; c < 28; c++) if (b_log[c]) busy_cnt++;
        n_total++;
        if (busy_cnt !== 0) $display("FAIL ill_idle_after: busy cycles=%0d want 0", busy_cnt);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < hs_cyc.size(); i++) if (hs_cyc[i] !== 5 + 5 * i) bad++;
        n_total++;
        if (hs_cyc.size() !== 4 || bad !== 0)
            $display("FAIL ill_timing: pixels=%0d wrong=%0d want 4 0", hs_cyc.size(), bad);
        else n_pass++;
    endtask

    initial begin
        load_mem();
        test_reset();
        test_nominal();
        test_backpressure();
        test_mismatch();
        test_reset_mid_frame();
        test_illegal_start();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/grayscale_frame_reader.md
# grayscale_frame_reader

Reads a stored grayscale frame back out of the byte-replicated result buffer and streams one grayscale byte per pixel to a downstream consumer, such as the Sobel window builder. The buffer holds each pixel as three identical bytes at consecutive addresses. The block fetches each triplet through a synchronous-read memory port and presents byte 0 on a valid/ready stream. It also flags any triplet whose three bytes disagree. It is the read side of the grayscale storage path.

## Interface
- RESULT_ARRAY_LEN, 51200: buffer size in bytes.
- ADDR_W, 16: memory address width; must satisfy 2^ADDR_W >= RESULT_ARRAY_LEN.
- PIXEL_COUNT, 17066: pixels per frame; 3*PIXEL_COUNT <= RESULT_ARRAY_LEN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame request; accepted only when busy=0.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  byte address; valid when mem_rd_en=1.
- mem_rd_data  in  8  read data; valid exactly 1 cycle after the mem_rd_en cycle.
- pix_valid  out  1  pixel available on pix_data.
- pix_ready  in  1  consumer accepts the pixel.
- pix_data  out  8  grayscale byte, taken from triplet byte 0.
- mismatch  out  1  sticky; set if any triplet in the current frame has b1!=b0 or b2!=b0.
- done  out  1  one-cycle pulse after the last pixel is accepted.

## Operation
- FSM states: IDLE, FETCH, DRAIN, PRESENT, FINISH.
- Registers: base (byte address), pix_cnt (0..PIXEL_COUNT-1), k (0..2), b0, b1.
- IDLE:
  - On start: base=0, pix_cnt=0, k=0, mismatch cleared, go to FETCH.
- FETCH (3 cycles):
  - mem_rd_en=1, mem_addr=base+k, k increments.
  - Data for k=0 is captured into b0 during the k=1 cycle; data for k=1 is captured into b1 during the k=2 cycle.
  - After k=2, go to DRAIN.
- DRAIN (1 cycle):
  - mem_rd_en=0; mem_rd_data holds b2.
  - pix_data<=b0.
  - mismatch<=mismatch | (b1!=b0) | (b2!=b0).
  - Go to PRESENT.
- PRESENT:
  - pix_valid=1; pix_data stays stable until a handshake (pix_valid & pix_ready).
  - On handshake:
    - If pix_cnt==PIXEL_COUNT-1, go to FINISH.
    - Otherwise base+=3, pix_cnt+=1, k=0, go to FETCH.
  - pix_valid drops the cycle after the handshake.
- FINISH (1 cycle):
  - done=1, busy=1; then IDLE.
- Address rules:
  - mem_addr never exceeds 3*PIXEL_COUNT-1.
  - Addresses are issued strictly ascending, with no repeats.
- Ignored inputs:
  - start when busy=1, including during FINISH.
  - pix_ready when pix_valid=0.
- No memory reads are issued while in PRESENT (no prefetch).

## Timing
- Reset value 0 for all outputs: busy, mem_rd_en, mem_addr, pix_valid, pix_data, mismatch, done. FSM goes to IDLE.
- Reset mid-frame aborts immediately; no done pulse is generated.
- With start sampled at cycle 0:
  - Cycles 1-3: FETCH, mem_addr 0,1,2.
  - Cycle 4: DRAIN.
  - Cycle 5: pix_valid=1.
- For a handshake at cycle t:
  - If more pixels remain: FETCH at t+1..t+3, next pix_valid at t+5.
  - If it was the last pixel: done at t+1, busy=0 at t+2.
- Minimum 5 cycles per pixel; any cycles with pix_ready low add directly to that.
- mismatch is updated at the DRAIN edge and becomes visible together with pix_valid. It holds through done and until the next accepted start.

## Test plan
Bench overrides PIXEL_COUNT=4 and uses a behavioural memory with 1-cycle read latency.

- **Reset:** assert rst mid-cycle -> all outputs 0 immediately, without waiting for a clock edge.
- **Nominal frame:**
  - Stimulus: memory[0..11]={10,10,10,20,20,20,30,30,30,40,40,40}, pix_ready=1, start at cycle 0.
  - Response: pixels 10/20/30/40 presented at cycles 5/10/15/20; done at cycle 21; busy=0 at cycle 22; mismatch=0; addresses 0..11 in order.
- **Backpressure:** pix_ready=0 for 7 cycles from cycle 5 -> pix_data held at 10, pix_valid held at 1, no mem_rd_en during the stall; pixel 20 is presented 5 cycles after the handshake.
- **Mismatch:** memory[4]=21 -> mismatch rises with pixel 1 (pix_data=20, cycle 10) and stays 1 through done. A new start clears it the cycle after it is accepted.
- **Reset mid-frame:** rst during FETCH of pixel 2 -> outputs 0, no done pulse. The next start reads from address 0 and completes normally.
- **Illegal start:** start pulsed at cycle 7 and at the done cycle -> both ignored. Exactly one done per accepted start; the address sequence is unchanged.
